// File: rtl/uart_rx_oversampled.sv
// 16x oversampling 8N1 UART receiver feeding the input FIFO.
// Majority-votes each bit, rejects false starts and reports frame/overrun events.
module uart_rx_oversampled #(
   parameter logic [31:0] CLOCK_FREQUENCY = 32'd50_000_000,
   parameter logic [31:0] BAUD_RATE       = 32'd115200,
   parameter int          OVERSAMPLE      = 16
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       din,
   input  logic       full,
   output logic [7:0] dout,
   output logic       we,
   output logic       frame_err,
   output logic       overrun,
   output logic       busy
);

   localparam logic [31:0] DIV      = CLOCK_FREQUENCY / (BAUD_RATE * 32'd16);
   localparam int          DIV_W    = (DIV > 32'd2) ? $clog2(DIV) : 1;
   localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(DIV - 32'd1);

   generate
      if (DIV < 32'd2) begin : g_div_check
         $fatal(1, "uart_rx_oversampled: CLOCK_FREQUENCY/(BAUD_RATE*16) must be at least 2");
      end
      if (OVERSAMPLE != 16) begin : g_os_check
         $fatal(1, "uart_rx_oversampled: only 16x oversampling is supported");
      end
   endgenerate

   typedef enum logic [1:0] {
      IDLE,
      START,
      DATA,
      STOP
   } state_t;

   state_t           state, state_next;
   logic             sync1, rx_s, rx_d;
   logic [DIV_W-1:0] div_cnt, div_next;
   logic             tick;
   logic [3:0]       s, s_next;
   logic [2:0]       b, b_next;
   logic [2:0]       smp, smp_next;
   logic [7:0]       shift, shift_next;
   logic [7:0]       dout_next;
   logic             we_next, fe_next, ov_next;
   logic             vote_stored, vote_stop;

   // Two-flop synchronizer plus one delay flop for falling-edge detection.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         sync1 <= 1'b1;
         rx_s  <= 1'b1;
         rx_d  <= 1'b1;
      end else begin
         sync1 <= din;
         rx_s  <= sync1;
         rx_d  <= rx_s;
      end
   end

   assign tick        = (div_cnt == DIV_LAST);
   assign vote_stored = (smp[0] & smp[1]) | (smp[0] & smp[2]) | (smp[1] & smp[2]);
   // The stop decision happens on the s=9 tick itself, so the third vote is the live sample.
   assign vote_stop   = (smp[0] & smp[1]) | (smp[0] & rx_s) | (smp[1] & rx_s);
   assign busy        = (state != IDLE);

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state     <= IDLE;
         div_cnt   <= '0;
         s         <= 4'd0;
         b         <= 3'd0;
         smp       <= 3'b111;
         shift     <= 8'h00;
         dout      <= 8'h00;
         we        <= 1'b0;
         frame_err <= 1'b0;
         overrun   <= 1'b0;
      end else begin
         state     <= state_next;
         div_cnt   <= div_next;
         s         <= s_next;
         b         <= b_next;
         smp       <= smp_next;
         shift     <= shift_next;
         dout      <= dout_next;
         we        <= we_next;
         frame_err <= fe_next;
         overrun   <= ov_next;
      end
   end

   always_comb begin
      state_next = state;
      div_next   = tick ? '0 : div_cnt + DIV_W'(1);
      s_next     = s;
      b_next     = b;
      smp_next   = smp;
      shift_next = shift;
      dout_next  = dout;
      we_next    = 1'b0;
      fe_next    = 1'b0;
      ov_next    = 1'b0;

      if (state != IDLE && tick) begin
         s_next = s + 4'd1;
         case (s)
            4'd7:    smp_next[0] = rx_s;
            4'd8:    smp_next[1] = rx_s;
            4'd9:    smp_next[2] = rx_s;
            default: ;
         endcase
      end

      case (state)
         IDLE: begin
            if (rx_d && !rx_s) begin
               state_next = START;
               div_next   = '0;
               s_next     = 4'd0;
               b_next     = 3'd0;
            end
         end
         START: begin
            if (tick && s == 4'd15) begin
               state_next = vote_stored ? IDLE : DATA;
            end
         end
         DATA: begin
            if (tick && s == 4'd15) begin
               shift_next = {vote_stored, shift[7:1]};
               b_next     = b + 3'd1;
               if (b == 3'd7) begin
                  state_next = STOP;
               end
            end
         end
         STOP: begin
            // Leave mid stop bit so the next start edge can be caught early.
            if (tick && s == 4'd9) begin
               state_next = IDLE;
               if (!vote_stop) begin
                  fe_next = 1'b1;
               end else if (full) begin
                  ov_next = 1'b1;
               end else begin
                  we_next   = 1'b1;
                  dout_next = shift;
               end
            end
         end
         default: state_next = IDLE;
      endcase
   end

endmodule

// File: tb/tb_uart_rx_oversampled.sv
// Scoreboard bench for uart_rx_oversampled: directed frames queue expected events,
// a negedge monitor pops and compares whenever we/frame_err/overrun fire.
module tb_uart_rx_oversampled;

   localparam int BIT_CLKS = 434;
   localparam logic [1:0] EV_WE = 2'd0;
   localparam logic [1:0] EV_FE = 2'd1;
   localparam logic [1:0] EV_OV = 2'd2;

   typedef struct packed {
      logic [1:0] kind;
      logic [7:0] data;
   } ev_t;

   logic       clk = 1'b0;
   logic       rst;
   logic       din;
   logic       full;
   logic [7:0] dout;
   logic       we;
   logic       frame_err;
   logic       overrun;
   logic       busy;

   int         checks = 0;
   int         errors = 0;
   int         cycle_cnt = 0;
   int         start_cycle = 0;
   bit         lat_check = 1'b0;
   int         dout_glitches = 0;
   logic [7:0] exp_dout = 8'h00;
   logic [7:0] last_dout = 8'h00;
   ev_t        sb_q[$];

   uart_rx_oversampled dut (
      .clk       (clk),
      .rst       (rst),
      .din       (din),
      .full      (full),
      .dout      (dout),
      .we        (we),
      .frame_err (frame_err),
      .overrun   (overrun),
      .busy      (busy)
   );

   always #10 clk = ~clk;

   always @(posedge clk) cycle_cnt <= cycle_cnt + 1;

   task automatic check_output(input string name, input logic [31:0] actual, input logic [31:0] expected);
      checks++;
      if (actual !== expected) begin
         errors++;
         $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
      end
   endtask

   task automatic push_event(input logic [1:0] kind, input logic [7:0] data);
      ev_t e;
      if (kind == EV_WE) exp_dout = data;
      e.kind = kind;
      e.data = exp_dout;
      sb_q.push_back(e);
   endtask

   task automatic apply_stimulus(input logic [7:0] data, input int bit_clks, input logic stop_val);
      din = 1'b0;
      start_cycle = cycle_cnt;
      repeat (bit_clks) @(negedge clk);
      for (int i = 0; i < 8; i++) begin
         din = data[i];
         repeat (bit_clks) @(negedge clk);
      end
      din = stop_val;
      repeat (bit_clks) @(negedge clk);
   endtask

   task automatic wait_drain(input string name);
      int n = 0;
      while (sb_q.size() != 0 && n < 1000) begin
         @(negedge clk);
         n++;
      end
      check_output(name, sb_q.size(), 0);
   endtask

   task automatic check_reset_outputs(input string tag);
      check_output({tag, "_dout"}, dout, 8'h00);
      check_output({tag, "_we"}, we, 1'b0);
      check_output({tag, "_frame_err"}, frame_err, 1'b0);
      check_output({tag, "_overrun"}, overrun, 1'b0);
      check_output({tag, "_busy"}, busy, 1'b0);
   endtask

   // Monitor: every output event must match the head of the scoreboard.
   always @(negedge clk) begin
      ev_t        e;
      logic [1:0] got_kind;
      int         lat;
      if (rst) begin
         if (we || frame_err || overrun) begin
            check_output("one_hot", 32'(we) + 32'(frame_err) + 32'(overrun), 1);
            got_kind = we ? EV_WE : (frame_err ? EV_FE : EV_OV);
            if (sb_q.size() == 0) begin
               checks++;
               errors++;
               $display("[TB] FAIL unexpected_event: got we=%0b frame_err=%0b overrun=%0b dout=%0h, expected none",
                        we, frame_err, overrun, dout);
            end else begin
               e = sb_q.pop_front();
               check_output("event_kind", got_kind, e.kind);
               check_output("event_dout", dout, e.data);
               if (lat_check && we) begin
                  lat = cycle_cnt - start_cycle;
                  checks++;
                  if (lat < 4155 || lat > 4161) begin
                     errors++;
                     $display("[TB] FAIL we_latency: got %0d clocks, expected 4155..4161", lat);
                  end
                  lat_check = 1'b0;
               end
            end
         end
         if (!we && dout !== last_dout) dout_glitches++;
      end
      last_dout = dout;
   end

   initial begin
      rst  = 1'b0;
      din  = 1'b1;
      full = 1'b0;
      repeat (5) @(negedge clk);
      check_reset_outputs("reset");
      rst = 1'b1;
      repeat (300) @(negedge clk);
      check_output("idle_after_reset_busy", busy, 1'b0);

      $display("[TB] single byte 0x55");
      lat_check = 1'b1;
      push_event(EV_WE, 8'h55);
      apply_stimulus(8'h55, BIT_CLKS, 1'b1);
      wait_drain("drain_55");
      repeat (200) @(negedge clk);

      $display("[TB] back-to-back 0x00, 0xFF");
      push_event(EV_WE, 8'h00);
      push_event(EV_WE, 8'hFF);
      apply_stimulus(8'h00, BIT_CLKS, 1'b1);
      apply_stimulus(8'hFF, BIT_CLKS, 1'b1);
      wait_drain("drain_00_ff");
      repeat (200) @(negedge clk);

      $display("[TB] start glitch then 0xA5");
      din = 1'b0;
      repeat (100) @(negedge clk);
      check_output("glitch_busy_high", busy, 1'b1);
      repeat (50) @(negedge clk);
      din = 1'b1;
      repeat (600) @(negedge clk);
      check_output("glitch_busy_low", busy, 1'b0);
      push_event(EV_WE, 8'hA5);
      apply_stimulus(8'hA5, BIT_CLKS, 1'b1);
      wait_drain("drain_a5");
      repeat (200) @(negedge clk);

      $display("[TB] frame error, break, then 0x12");
      push_event(EV_FE, 8'h00);
      apply_stimulus(8'h3C, BIT_CLKS, 1'b0);
      wait_drain("drain_fe");
      repeat (3 * 10 * BIT_CLKS) @(negedge clk);
      check_output("break_busy", busy, 1'b0);
      din = 1'b1;
      repeat (500) @(negedge clk);
      push_event(EV_WE, 8'h12);
      apply_stimulus(8'h12, BIT_CLKS, 1'b1);
      wait_drain("drain_12");
      repeat (200) @(negedge clk);

      $display("[TB] overrun on 0x77, then accepted 0x77");
      full = 1'b1;
      push_event(EV_OV, 8'h00);
      apply_stimulus(8'h77, BIT_CLKS, 1'b1);
      wait_drain("drain_ov");
      full = 1'b0;
      repeat (200) @(negedge clk);
      push_event(EV_WE, 8'h77);
      apply_stimulus(8'h77, BIT_CLKS, 1'b1);
      wait_drain("drain_77");
      repeat (200) @(negedge clk);

      $display("[TB] reset during 0xC3, then 0x81 at nominal and +/-3%% baud");
      fork
         apply_stimulus(8'hC3, BIT_CLKS, 1'b1);
         begin
            repeat (5 * BIT_CLKS + 200) @(negedge clk);
            rst = 1'b0;
            repeat (2) @(negedge clk);
            check_reset_outputs("midframe_reset");
         end
      join
      repeat (100) @(negedge clk);
      check_reset_outputs("held_reset");
      rst = 1'b1;
      exp_dout = 8'h00;
      repeat (300) @(negedge clk);
      check_output("post_reset_busy", busy, 1'b0);
      push_event(EV_WE, 8'h81);
      apply_stimulus(8'h81, BIT_CLKS, 1'b1);
      wait_drain("drain_81_nom");
      repeat (200) @(negedge clk);
      push_event(EV_WE, 8'h81);
      apply_stimulus(8'h81, 447, 1'b1);
      wait_drain("drain_81_slow");
      repeat (200) @(negedge clk);
      push_event(EV_WE, 8'h81);
      apply_stimulus(8'h81, 421, 1'b1);
      wait_drain("drain_81_fast");
      repeat (500) @(negedge clk);

      check_output("dout_changed_without_we", dout_glitches, 0);
      check_output("final_dout", dout, 8'h81);
      check_output("scoreboard_empty", sb_q.size(), 0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
